sliding_dft_bank: RTL and testbench

Parametrised, time-multiplexed sliding-DFT engine that replaces the per-sample multiplier and the flat shift-register sample store. It keeps a ring buffer of the last DEPTH samples and updates BINS running sin/cos accumulators per accepted sample as (new − oldest) × coefficient. It emits one alpha-max-beta-min magnitude per bin, and sits between the sample source and the octave/bin folding logic. Sin/cos values come from the external coefficient tables, which are addressed by this block.

---
 rtl/sliding_dft_bank.sv | 166 ++++++++++++++++
 tb/tb_sliding_dft_bank.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_dft_bank.sv
// Time-multiplexed sliding DFT: one sample per sweep is folded into BINS sin/cos
// accumulators as (new - oldest) * coefficient; one magnitude estimate is streamed out per bin.
module sliding_dft_bank #(
  parameter int SAMPLE_W = 16,
  parameter int COEF_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int BINS     = 24,
  parameter int ACC_W    = SAMPLE_W + COEF_W + 1 + $clog2(DEPTH),
  localparam int BIN_W   = (BINS > 1) ? $clog2(BINS) : 1,
  localparam int PH_W    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic signed [SAMPLE_W-1:0] inSample,
  output logic [BIN_W-1:0]           coefBin,
  output logic [PH_W-1:0]            coefPhase,
  input  logic signed [COEF_W-1:0]   sinValue,
  input  logic signed [COEF_W-1:0]   cosValue,
  output logic                       outValid,
  output logic [BIN_W-1:0]           outBin,
  output logic [ACC_W-1:0]           outMagnitude,
  output logic                       outLast
);

  localparam int DIFF_W = SAMPLE_W + 1;
  localparam int PROD_W = DIFF_W + COEF_W;
  localparam int EXT_W  = ACC_W - PROD_W;

  typedef enum logic [1:0] {S_IDLE, S_DIFF, S_SWEEP} state_t;

  state_t                     r_state, w_state_next;
  logic signed [SAMPLE_W-1:0] r_mem [DEPTH];
  logic signed [SAMPLE_W-1:0] r_rd_data;
  logic signed [SAMPLE_W-1:0] r_new;
  logic [PH_W-1:0]            r_wr_ptr;
  logic [PH_W-1:0]            r_phase;
  logic                       r_primed;
  logic signed [DIFF_W-1:0]   r_diff;
  logic [BIN_W-1:0]           r_bin;
  logic signed [ACC_W-1:0]    r_acc_sin [BINS];
  logic signed [ACC_W-1:0]    r_acc_cos [BINS];

  logic                       r_out_valid;
  logic                       r_out_last;
  logic [BIN_W-1:0]           r_out_bin;
  logic [ACC_W-1:0]           r_out_mag;

  logic                       w_accept;
  logic                       w_sweep;
  logic                       w_last_bin;
  logic signed [PROD_W-1:0]   w_prod_sin, w_prod_cos;
  logic signed [ACC_W-1:0]    w_sin_upd, w_cos_upd;
  logic [ACC_W-1:0]           w_abs_sin, w_abs_cos;
  logic [ACC_W-1:0]           w_hi, w_lo, w_mag;

  assign w_accept   = (r_state == S_IDLE) && inValid;
  assign w_sweep    = (r_state == S_SWEEP);
  assign w_last_bin = (r_bin == BIN_W'(BINS - 1));

  assign inReady      = (r_state == S_IDLE);
  assign coefBin      = w_sweep ? r_bin : '0;
  assign coefPhase    = w_sweep ? r_phase : r_wr_ptr;
  assign outValid     = r_out_valid;
  assign outLast      = r_out_last;
  assign outBin       = r_out_bin;
  assign outMagnitude = r_out_mag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (inValid) w_state_next = S_DIFF;
      S_DIFF:  w_state_next = S_SWEEP;
      S_SWEEP: if (w_last_bin) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sample store: read of the oldest sample at accept, overwrite with the new one in DIFF.
  always_ff @(posedge clk) begin
    if (w_accept) r_rd_data <= r_mem[r_wr_ptr];
    if (r_state == S_DIFF) r_mem[r_wr_ptr] <= r_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_new    <= '0;
      r_phase  <= '0;
      r_wr_ptr <= '0;
      r_primed <= 1'b0;
      r_diff   <= '0;
      r_bin    <= '0;
    end else begin
      if (w_accept) begin
        r_new   <= inSample;
        r_phase <= r_wr_ptr;
      end
      if (r_state == S_DIFF) begin
        // Until the buffer has wrapped once, the history is implicitly zero.
        r_diff   <= {r_new[SAMPLE_W-1], r_new}
                    - (r_primed ? {r_rd_data[SAMPLE_W-1], r_rd_data} : '0);
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == PH_W'(DEPTH - 1)) r_primed <= 1'b1;
        r_bin    <= '0;
      end
      if (w_sweep) r_bin <= r_bin + 1'b1;
    end
  end

  assign w_prod_sin = r_diff * sinValue;
  assign w_prod_cos = r_diff * cosValue;
  assign w_sin_upd  = r_acc_sin[r_bin] + {{EXT_W{w_prod_sin[PROD_W-1]}}, w_prod_sin};
  assign w_cos_upd  = r_acc_cos[r_bin] + {{EXT_W{w_prod_cos[PROD_W-1]}}, w_prod_cos};

  generate
    for (genvar gi = 0; gi < BINS; gi++) begin : g_acc
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_acc_sin[gi] <= '0;
          r_acc_cos[gi] <= '0;
        end else if (w_sweep && (r_bin == BIN_W'(gi))) begin
          r_acc_sin[gi] <= w_sin_upd;
          r_acc_cos[gi] <= w_cos_upd;
        end
      end
    end
  endgenerate

  function automatic logic [ACC_W-1:0] abs_sat(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] res;
    if (v == {1'b1, {(ACC_W-1){1'b0}}}) res = {1'b0, {(ACC_W-1){1'b1}}};
    else if (v[ACC_W-1])                res = -v;
    else                                res = v;
    return res;
  endfunction

  // Alpha-max-beta-min with alpha=1, beta=1/2 on the freshly updated accumulators.
  assign w_abs_sin = abs_sat(w_sin_upd);
  assign w_abs_cos = abs_sat(w_cos_upd);
  assign w_hi      = (w_abs_sin >= w_abs_cos) ? w_abs_sin : w_abs_cos;
  assign w_lo      = (w_abs_sin >= w_abs_cos) ? w_abs_cos : w_abs_sin;
  assign w_mag     = w_hi + (w_lo >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_bin   <= '0;
      r_out_mag   <= '0;
    end else begin
      r_out_valid <= w_sweep;
      r_out_last  <= w_sweep && w_last_bin;
      if (w_sweep) begin
        r_out_bin <= r_bin;
        r_out_mag <= w_mag;
      end
    end
  end

endmodule

// File: tb/tb_sliding_dft_bank.sv
// Bench for sliding_dft_bank (DEPTH=8, BINS=4): window-based reference model with a
// cycle-stamped scoreboard, directed literal checks and a randomized coefficient/sample run.
module tb_sliding_dft_bank;
  localparam int SW = 16;
  localparam int CW = 16;
  localparam int D  = 8;
  localparam int B  = 4;
  localparam int AW = SW + CW + 1 + $clog2(D);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 inValid = 1'b0;
  logic signed [SW-1:0] inSample = '0;
  logic                 inReady;
  logic [1:0]           coefBin;
  logic [2:0]           coefPhase;
  logic signed [CW-1:0] sinValue, cosValue;
  logic                 outValid;
  logic [1:0]           outBin;
  logic [AW-1:0]        outMagnitude;
  logic                 outLast;

  sliding_dft_bank #(.SAMPLE_W(SW), .COEF_W(CW), .DEPTH(D), .BINS(B)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inSample(inSample),
    .coefBin(coefBin), .coefPhase(coefPhase), .sinValue(sinValue), .cosValue(cosValue),
    .outValid(outValid), .outBin(outBin), .outMagnitude(outMagnitude), .outLast(outLast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient stub: constants, or random per-(bin,phase) tables.
  logic                 coef_mode = 1'b0;
  logic signed [CW-1:0] c_sin = '0, c_cos = '0;
  logic signed [CW-1:0] sin_tab [B][D];
  logic signed [CW-1:0] cos_tab [B][D];
  assign sinValue = coef_mode ? sin_tab[coefBin][coefPhase] : c_sin;
  assign cosValue = coef_mode ? cos_tab[coefBin][coefPhase] : c_cos;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int bin; longint mag; bit last; } exp_t;
  exp_t   sb[$];
  longint hist [D];
  longint m_sacc [B];
  longint m_cacc [B];
  longint model_mag [B];
  longint dut_mag [B];
  longint dut_bin0_q[$];
  int     drv_acc_q[$];
  int     n_acc = 0;
  int     last_acc = 0;
  bit     have_acc = 1'b0;
  int     acc_phase = 0;
  int     dut_phase_seen = -1;

  function automatic longint wrap_acc(input longint v);
    logic signed [AW-1:0] t;
    t = v[AW-1:0];
    return longint'(t);
  endfunction

  function automatic longint mag_of(input longint s, input longint c);
    longint maxp, a, b2, hi, lo;
    maxp = (longint'(1) <<< (AW - 1)) - 1;
    a  = (s < 0) ? -s : s;
    b2 = (c < 0) ? -c : c;
    if (a > maxp)  a  = maxp;
    if (b2 > maxp) b2 = maxp;
    hi = (a > b2) ? a : b2;
    lo = (a > b2) ? b2 : a;
    return (hi + lo / 2) & ((longint'(1) <<< AW) - 1);
  endfunction

  function automatic longint coef_s(input int b, input int p);
    return coef_mode ? longint'(sin_tab[b][p]) : longint'(c_sin);
  endfunction
  function automatic longint coef_c(input int b, input int p);
    return coef_mode ? longint'(cos_tab[b][p]) : longint'(c_cos);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) hist[i] = 0;
    for (int b = 0; b < B; b++) begin m_sacc[b] = 0; m_cacc[b] = 0; end
    sb.delete();
    n_acc = 0;
    have_acc = 1'b0;
  endtask

  task automatic model_accept(input longint s);
    int ph;
    longint diff, mg;
    exp_t e;
    ph = n_acc % D;
    diff = s - hist[ph];
    hist[ph] = s;
    for (int b = 0; b < B; b++) begin
      m_sacc[b] = wrap_acc(m_sacc[b] + diff * coef_s(b, ph));
      m_cacc[b] = wrap_acc(m_cacc[b] + diff * coef_c(b, ph));
      mg = mag_of(m_sacc[b], m_cacc[b]);
      model_mag[b] = mg;
      e.cyc = cyc + 3 + b; e.bin = b; e.mag = mg; e.last = (b == B - 1);
      sb.push_back(e);
    end
    n_acc++;
    last_acc = cyc;
    have_acc = 1'b1;
    acc_phase = ph;
  endtask

  // ---------------- compare process ----------------
  initial begin
    bit exp_ready;
    int d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_inReady", longint'(inReady), 1);
        check("rst_outValid", longint'(outValid), 0);
        check("rst_outLast", longint'(outLast), 0);
        check("rst_outBin", longint'(outBin), 0);
        check("rst_outMagnitude", longint'(outMagnitude), 0);
        check("rst_coefBin", longint'(coefBin), 0);
        check("rst_coefPhase", longint'(coefPhase), 0);
        model_reset();
      end else begin
        d = cyc - last_acc;
        exp_ready = !have_acc || (d >= B + 2);
        check("inReady", longint'(inReady), longint'(exp_ready));
        if (have_acc && d >= 2 && d <= B + 1) begin
          check("sweep_coefBin", longint'(coefBin), longint'(d - 2));
          check("sweep_coefPhase", longint'(coefPhase), longint'(acc_phase));
          if (d == 2) dut_phase_seen = int'(coefPhase);
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          tests++; fails++;
          $display("FAIL missing_output: bin %0d expected at cycle %0d, outValid never asserted", sb[0].bin, sb[0].cyc);
          void'(sb.pop_front());
        end
        if (outValid) begin
          dut_mag[outBin] = longint'(outMagnitude);
          if (outBin == 2'd0) dut_bin0_q.push_back(longint'(outMagnitude));
          if (sb.size() > 0 && sb[0].cyc == cyc) begin
            check("outBin", longint'(outBin), longint'(sb[0].bin));
            check("outMagnitude", longint'(outMagnitude), sb[0].mag);
            check("outLast", longint'(outLast), longint'(sb[0].last));
            void'(sb.pop_front());
          end else begin
            tests++; fails++;
            $display("FAIL unexpected_output: outValid=1 bin %0d mag %0d, required outValid=0", outBin, outMagnitude);
          end
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
          tests++; fails++;
          $display("FAIL missing_output: outValid=0, required 1 for bin %0d", sb[0].bin);
          void'(sb.pop_front());
        end
        if (inValid && exp_ready) model_accept(longint'(inSample));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic signed [SW-1:0] s, input bit keep);
    int t;
    inSample = s;
    inValid  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!inReady && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!inReady) begin
      tests++; fails++;
      $display("FAIL accept_timeout: inReady=0 for 100 cycles, required 1");
    end else begin
      drv_acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (!keep) inValid = 1'b0;
  endtask

  task automatic drain();
    repeat (B + 4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("post_rst_inReady", longint'(inReady), 1);
    check("post_rst_outValid", longint'(outValid), 0);
    check("post_rst_outMagnitude", longint'(outMagnitude), 0);
    check("post_rst_coefPhase", longint'(coefPhase), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [SW-1:0] v;
    int gap;
    int n;

    // Reset.
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("init_inReady", longint'(inReady), 1);
    check("init_outValid", longint'(outValid), 0);

    // Single sample.
    do_reset();
    c_sin = 16'sd16384; c_cos = 16'sd0;
    send(16'sd100, 1'b0);
    drain();
    for (int b = 0; b < B; b++) begin
      check("single_dut_mag", dut_mag[b], 64'd1638400);
      check("single_model_mag", model_mag[b], 64'd1638400);
    end
    check("single_phase", longint'(dut_phase_seen), 0);

    // Magnitude formula.
    do_reset();
    c_sin = 16'sd3000; c_cos = 16'sd4000;
    send(16'sd1, 1'b0);
    drain();
    check("mag_a_dut", dut_mag[2], 64'd5500);
    check("mag_a_model", model_mag[2], 64'd5500);
    do_reset();
    c_sin = -16'sd4000; c_cos = 16'sd3000;
    send(16'sd1, 1'b0);
    drain();
    check("mag_b_dut", dut_mag[1], 64'd5500);
    check("mag_b_model", model_mag[1], 64'd5500);

    // Window slide.
    do_reset();
    c_sin = 16'sd1; c_cos = 16'sd0;
    for (int i = 0; i < D; i++) send(16'sd10, 1'b0);
    drain();
    check("win_fill_dut", dut_mag[0], 64'd80);
    send(16'sd10, 1'b0);
    drain();
    check("win_primed_dut", dut_mag[0], 64'd80);
    check("win_primed_phase", longint'(dut_phase_seen), 0);
    send(-16'sd10, 1'b0);
    drain();
    check("win_neg_dut", dut_mag[0], 64'd60);
    check("win_neg_model", model_mag[0], 64'd60);

    // Back-to-back handshake with inValid held high.
    do_reset();
    c_sin = 16'sd1; c_cos = 16'sd0;
    dut_bin0_q.delete();
    drv_acc_q.delete();
    send(16'sd1, 1'b1);
    send(16'sd2, 1'b1);
    send(16'sd3, 1'b0);
    drain();
    n = drv_acc_q.size();
    check("b2b_accepts", longint'(n), 3);
    if (n == 3) begin
      check("b2b_gap1", longint'(drv_acc_q[1] - drv_acc_q[0]), 6);
      check("b2b_gap2", longint'(drv_acc_q[2] - drv_acc_q[1]), 6);
    end
    n = dut_bin0_q.size();
    check("b2b_bin0_count", longint'(n), 3);
    if (n == 3) begin
      check("b2b_mag1", dut_bin0_q[0], 1);
      check("b2b_mag2", dut_bin0_q[1], 3);
      check("b2b_mag3", dut_bin0_q[2], 6);
    end

    // Reset mid-sweep.
    do_reset();
    c_sin = 16'sd1; c_cos = 16'sd0;
    send(16'sd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst_before_valid", longint'(outValid), 1);
    #1 rst = 1'b0;
    #1;
    check("midrst_outValid", longint'(outValid), 0);
    check("midrst_outLast", longint'(outLast), 0);
    check("midrst_inReady", longint'(inReady), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(16'sd5, 1'b0);
    drain();
    for (int b = 0; b < B; b++) check("midrst_after_mag", dut_mag[b], 64'd5);

    // Randomized coefficients and samples across several window wraps.
    do_reset();
    for (int b = 0; b < B; b++)
      for (int p = 0; p < D; p++) begin
        sin_tab[b][p] = CW'($urandom);
        cos_tab[b][p] = CW'($urandom);
      end
    coef_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      v = SW'($urandom);
      send(v, 1'b0);
    end
    drain();
    coef_mode = 1'b0;

    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
